coeff_deserializer: RTL



---
 rtl/coeff_deserializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/coeff_deserializer.sv
// coeff_deserializer: gathers serial 13-bit DCT coefficients into 8-wide frames for the IDCT.
// Revision 1.0 - initial release.
`default_nettype none

module coeff_deserializer #(
  parameter int WIDTH = 13,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic [WIDTH-1:0] dout4,
  output logic [WIDTH-1:0] dout5,
  output logic [WIDTH-1:0] dout6,
  output logic [WIDTH-1:0] dout7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_sof
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } ostate_t;

  ostate_t          state;
  ostate_t          state_nxt;
  logic [2:0]       cnt;
  logic             col_full;
  logic [WIDTH-1:0] col   [N];
  logic [WIDTH-1:0] obank [N];

  logic       accept;
  logic       restart;
  logic [2:0] idx;
  logic       complete;
  logic       out_free;
  logic       load_new;
  logic       drain;
  logic       stall;

  assign in_ready = !col_full;
  assign accept   = in_valid && in_ready;
  // A start-of-frame always writes slot 0; it only flags an error if a partial frame is dropped.
  assign idx      = in_sof ? 3'd0 : cnt;
  assign restart  = accept && in_sof && (cnt != 3'd0);
  assign complete = accept && (idx == 3'(N-1));

  always_comb begin
    state_nxt = state;
    out_free  = (state == EMPTY) || out_ready;
    load_new  = complete && out_free;
    drain     = col_full && out_ready;
    stall     = complete && !out_free;
    case (state)
      EMPTY:   if (load_new) state_nxt = HOLD;
      HOLD:    if (out_ready && !load_new && !drain) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      cnt      <= 3'd0;
      col_full <= 1'b0;
      err_sof  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        col[i]   <= '0;
        obank[i] <= '0;
      end
    end else begin
      state   <= state_nxt;
      err_sof <= restart;
      if (accept) begin
        col[idx] <= din;
        cnt      <= (idx == 3'(N-1)) ? 3'd0 : idx + 3'd1;
      end
      if (stall) col_full <= 1'b1;
      else if (drain) col_full <= 1'b0;
      // The final beat of a frame bypasses the collect bank when the output bank is free.
      if (load_new || drain) begin
        for (int i = 0; i < N-1; i++) obank[i] <= col[i];
        obank[N-1] <= load_new ? din : col[N-1];
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign dout0 = obank[0];
  assign dout1 = obank[1];
  assign dout2 = obank[2];
  assign dout3 = obank[3];
  assign dout4 = obank[4];
  assign dout5 = obank[5];
  assign dout6 = obank[6];
  assign dout7 = obank[7];

endmodule

`default_nettype wire
